// File: rtl/pdm_demod_pkg.sv
// -----------------------------------------------------------------------------
// pdm_demod_pkg
// Shared definitions for the PDM receive path: default CIC geometry, the
// mapping of a PDM bit onto a +/-1 step, and the positive-saturation helper
// used by the demodulator output stage and by filter test logic.
// No ports (package).
// -----------------------------------------------------------------------------
package pdm_demod_pkg;

    // Default CIC geometry: third order, decimation ratio 2^5 = 32.
    localparam int ORDER_DEF      = 3;
    localparam int DECIM_LOG2_DEF = 5;

    // PDM bit value mapping: a 1 contributes +1, a 0 contributes -1.
    localparam logic signed [1:0] PDM_POS = 2'sb01;
    localparam logic signed [1:0] PDM_NEG = 2'sb11;

    // Working width of the saturation helper; wide enough for any legal
    // ORDER*DECIM_LOG2 combination.
    localparam int SAT_W = 64;

    // Clamp v to the largest positive value representable in out_w signed
    // bits. Negative values are passed through untouched: a CIC output never
    // goes below -2^(out_w-1), so only the single +2^(out_w-1) case needs help.
    function automatic logic signed [SAT_W-1:0] sat_pos(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             out_w
    );
        logic signed [SAT_W-1:0] lim;
        lim = SAT_W'(1);
        lim = (lim <<< (out_w - 1)) - SAT_W'(1);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/pdm_demod_comb.sv
// -----------------------------------------------------------------------------
// cic_comb
// One CIC comb (differentiator) stage with differential delay 1:
//   y_o = x_i - x_i(previous enabled cycle), all modulo 2^W.
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  synchronous active-low clear of the delay register
//   en_i   in  1  captures x_i into the delay register on this edge
//   x_i    in  W  stage input
//   y_o    out W  combinational difference
// -----------------------------------------------------------------------------
module cic_comb
    import pdm_demod_pkg::*;
#(
    parameter int W = ORDER_DEF * DECIM_LOG2_DEF + 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o
);

    logic [W-1:0] dly_q;

    // Wrapping subtraction is intended; the CIC relies on modulo arithmetic.
    assign y_o = x_i - dly_q;

    // NOTE: state registers use non-blocking assignments so every stage reads
    // the pre-edge value of its neighbour, independent of process order.
    // NOTE: the delay register is cleared on reset like any other state; a
    // stale value here would leak into the first sample after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dly_q <= '0;
        end else if (en_i) begin
            dly_q <= x_i;
        end
    end

endmodule

// File: rtl/pdm_demod.sv
// -----------------------------------------------------------------------------
// pdm_demod
// CIC decimator that turns a 1-bit pulse-density stream back into signed PCM.
// ORDER integrators run at the bit rate, ORDER combs run at the frame rate
// (one frame = 2^DECIM_LOG2 accepted bits), then a saturating output register.
// Ports:
//   clk         in  1      rising-edge clock
//   rst_n       in  1      synchronous active-low reset
//   in_en       in  1      qualifies in_bit on this cycle
//   in_bit      in  1      PDM bit, 1 -> +1, 0 -> -1
//   out_sample  out OUT_W  signed decimated sample, held between strobes
//   out_valid   out 1      one-cycle strobe marking a new out_sample
// Latency: last bit of a frame accepted at edge k -> out_valid after edge k+2.
// -----------------------------------------------------------------------------
module pdm_demod
    import pdm_demod_pkg::*;
#(
    parameter int  ORDER      = ORDER_DEF,
    parameter int  DECIM_LOG2 = DECIM_LOG2_DEF,
    localparam int W          = ORDER * DECIM_LOG2 + 2,
    localparam int OUT_W      = ORDER * DECIM_LOG2 + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_en,
    input  logic                    in_bit,
    output logic signed [OUT_W-1:0] out_sample,
    output logic                    out_valid
);

    // ---------------------------------------------------------------- input map
    logic signed [1:0] in_val;
    logic [W-1:0]      step;

    assign in_val = in_bit ? PDM_POS : PDM_NEG;
    assign step   = W'(in_val);   // sign-extends the +/-1

    // ------------------------------------------------------------- integrators
    // The chain is combinational within one cycle so that, after the edge that
    // accepts a bit, the last integrator already contains that bit.
    for (genvar k = 0; k < ORDER; k++) begin : g_int
        logic [W-1:0] acc_q;
        logic [W-1:0] acc_d;

        if (k == 0) begin : g_first
            assign acc_d = acc_q + step;
        end else begin : g_next
            assign acc_d = acc_q + g_int[k-1].acc_d;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                acc_q <= '0;
            end else if (in_en) begin
                acc_q <= acc_d;
            end
        end
    end

    // ------------------------------------------------------ decimation counter
    logic [DECIM_LOG2-1:0] cnt_q;
    logic [DECIM_LOG2-1:0] cnt_d;
    logic                  frame_end;
    logic                  dec_stb_q;

    assign cnt_d     = cnt_q + 1'b1;          // wraps from R-1 to 0
    assign frame_end = in_en && (&cnt_q);     // accepted bit at count R-1

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            dec_stb_q <= 1'b0;
        end else begin
            if (in_en) begin
                cnt_q <= cnt_d;
            end
            dec_stb_q <= frame_end;
        end
    end

    // ------------------------------------------------------------------- combs
    for (genvar k = 0; k < ORDER; k++) begin : g_comb
        logic [W-1:0] x;
        logic [W-1:0] y;

        if (k == 0) begin : g_first
            assign x = g_int[ORDER-1].acc_q;
        end else begin : g_next
            assign x = g_comb[k-1].y;
        end

        cic_comb #(
            .W (W)
        ) u_comb (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (dec_stb_q),
            .x_i   (x),
            .y_o   (y)
        );
    end

    // ------------------------------------------------------------ output stage
    // Comb result is registered first, then saturated/truncated into the port.
    logic signed [W-1:0]     comb_res_q;
    logic                    res_stb_q;
    logic signed [SAT_W-1:0] res_ext;
    logic signed [OUT_W-1:0] out_d;

    assign res_ext = SAT_W'(comb_res_q);
    // The comb result spans [-2^(W-2), +2^(W-2)]; only the top value needs
    // clamping, everything else fits OUT_W bits exactly.
    assign out_d   = OUT_W'(sat_pos(res_ext, OUT_W));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            comb_res_q <= '0;
            res_stb_q  <= 1'b0;
            out_sample <= '0;
            out_valid  <= 1'b0;
        end else begin
            if (dec_stb_q) begin
                comb_res_q <= g_comb[ORDER-1].y;
            end
            res_stb_q <= dec_stb_q;
            if (res_stb_q) begin
                out_sample <= out_d;
            end
            out_valid <= res_stb_q;
        end
    end

endmodule

// File: tb/tb_pdm_demod.sv
// -----------------------------------------------------------------------------
// tb_pdm_demod
// Scoreboard bench for pdm_demod at default geometry. Expected samples come
// from a direct FIR model: the CIC impulse response (a boxcar of length R
// convolved ORDER times) applied to the history of accepted +/-1 bits, then
// clamped. Each closed frame pushes {value, due cycle}; the monitor pops on
// out_valid and checks value and latency, and checks hold between strobes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pdm_demod;
    import pdm_demod_pkg::*;

    localparam int     ORDER   = ORDER_DEF;
    localparam int     DL      = DECIM_LOG2_DEF;
    localparam int     R       = 1 << DL;
    localparam int     OUT_W   = ORDER * DL + 1;
    localparam int     HLEN    = ORDER * (R - 1) + 1;
    localparam longint OUT_MAX = (longint'(1) <<< (OUT_W - 1)) - 1;
    localparam int     HMAX    = 1024;

    typedef struct {
        longint value;
        int     due;
    } exp_t;

    logic                    clk    = 1'b0;
    logic                    rst_n  = 1'b0;
    logic                    in_en  = 1'b0;
    logic                    in_bit = 1'b0;
    logic signed [OUT_W-1:0] out_sample;
    logic                    out_valid;

    pdm_demod #(
        .ORDER      (ORDER),
        .DECIM_LOG2 (DL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_en      (in_en),
        .in_bit     (in_bit),
        .out_sample (out_sample),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------ bookkeeping
    int       n_tests = 0;
    int       n_fail  = 0;
    exp_t     sb[$];
    longint   obs[$];
    int       obs_cyc[$];
    int       h[HLEN];
    int       hist[HMAX];
    int       n_acc   = 0;
    longint   hold_ref = 0;
    bit       mon_en  = 1'b0;
    exp_t     mon_e;
    longint   s1_exp[4] = '{5984, 27808, 32767, 32767};

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------ model
    task automatic build_h();
        int cur[HLEN];
        int nxt[HLEN];
        foreach (cur[i]) cur[i] = (i < R) ? 1 : 0;
        for (int s = 1; s < ORDER; s++) begin
            foreach (nxt[i]) begin
                nxt[i] = 0;
                for (int j = 0; j < R; j++) begin
                    if (i - j >= 0) nxt[i] += cur[i-j];
                end
            end
            cur = nxt;
        end
        h = cur;
    endtask

    function automatic longint model_sample(input int n);
        longint acc;
        acc = 0;
        for (int j = 0; j < HLEN; j++) begin
            if (n - 1 - j >= 0) acc += longint'(h[j]) * longint'(hist[n-1-j]);
        end
        if (acc > OUT_MAX) acc = OUT_MAX;
        return acc;
    endfunction

    // ---------------------------------------------------------------- drivers
    task automatic drive_bit(input logic en, input logic b);
        exp_t e;
        @(posedge clk);
        #1;
        in_en  = en;
        in_bit = b;
        if (en) begin
            hist[n_acc] = b ? 1 : -1;
            n_acc++;
            if (n_acc % R == 0) begin
                e.value = model_sample(n_acc);
                e.due   = cyc + 3;   // accepted next edge, visible two edges later
                sb.push_back(e);
            end
        end
    endtask

    function automatic logic pat_bit(input int kind, input int i);
        case (kind)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (i % 2) == 0;
            3:       return (i % 4) != 3;
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_bits(input int kind, input int nbits, input bit gap);
        for (int i = 0; i < nbits; i++) begin
            drive_bit(1'b1, pat_bit(kind, i));
            if (gap) drive_bit(1'b0, pat_bit(kind, i));
        end
    endtask

    // First-order sigma-delta modulator for a DC level in units of 1/1024.
    task automatic run_sd(input int level, input int nbits);
        int  acc;
        logic b;
        acc = 0;
        for (int i = 0; i < nbits; i++) begin
            b = (acc >= 0);
            acc += level - (b ? 1024 : -1024);
            drive_bit(1'b1, b);
        end
    endtask

    task automatic idle_drain(input string tag);
        for (int i = 0; i < 8; i++) drive_bit(1'b0, 1'b0);
        check({tag, "_drain"}, sb.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        in_en  = 1'b0;
        in_bit = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        obs.delete();
        obs_cyc.delete();
        n_acc    = 0;
        hold_ref = 0;
        mon_en   = 1'b1;
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_sample", out_sample, 0);
    endtask

    task automatic check_tail(input string tag, input int first, input longint exp);
        for (int i = first; i < obs.size(); i++) check(tag, obs[i], exp);
    endtask

    task automatic check_period(input string tag, input int per);
        for (int i = 1; i < obs_cyc.size(); i++) check(tag, obs_cyc[i] - obs_cyc[i-1], per);
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", out_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("sample", out_sample, mon_e.value);
                    check("latency", cyc, mon_e.due);
                end
                obs.push_back(longint'(out_sample));
                obs_cyc.push_back(cyc);
                hold_ref = longint'(out_sample);
            end else begin
                check("hold", out_sample, hold_ref);
            end
        end
    end

    // --------------------------------------------------------------- watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        build_h();

        // All ones from reset.
        do_reset();
        run_bits(0, 6 * R, 1'b0);
        idle_drain("ones");
        check("ones_count", obs.size(), 6);
        if (obs.size() >= 6) begin
            check("ones_first", obs[0], 5984);
            check("ones_second", obs[1], 27808);
            check_tail("ones_sat", 2, 32767);
        end
        check_period("ones_period", R);

        // All zeros: full negative scale, no wrap.
        do_reset();
        run_bits(1, 5 * R, 1'b0);
        idle_drain("zeros");
        check("zeros_count", obs.size(), 5);
        if (obs.size() >= 3) check_tail("zeros_ss", 2, -32768);

        // Alternating 1,0 -> zero.
        do_reset();
        run_bits(2, 5 * R, 1'b0);
        idle_drain("alt");
        check("alt_count", obs.size(), 5);
        if (obs.size() >= 3) check_tail("alt_ss", 2, 0);

        // Three of every four ones -> half positive scale.
        do_reset();
        run_bits(3, 5 * R, 1'b0);
        idle_drain("three4");
        check("three4_count", obs.size(), 5);
        if (obs.size() >= 3) check_tail("three4_ss", 2, 16384);

        // in_en toggled every other cycle on all ones.
        do_reset();
        run_bits(0, 4 * R, 1'b1);
        idle_drain("gap");
        check("gap_count", obs.size(), 4);
        if (obs.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("gap_value", obs[i], s1_exp[i]);
        end
        check_period("gap_period", 2 * R);

        // Reset at count 17 of the fifth frame, then restart.
        do_reset();
        run_bits(0, 4 * R + 17, 1'b0);
        check("midrst_pre_count", obs.size(), 4);
        do_reset();
        run_bits(0, 4 * R, 1'b0);
        idle_drain("midrst");
        check("midrst_count", obs.size(), 4);
        if (obs.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("midrst_value", obs[i], s1_exp[i]);
        end

        // Sigma-delta DC level 0.3 of full scale: positive plateau near 9824.
        do_reset();
        run_sd(307, 8 * R);
        idle_drain("sd");
        check("sd_count", obs.size(), 8);
        for (int i = 2; i < obs.size(); i++) begin
            check("sd_positive", obs[i] >= 0, 1);
            check("sd_level", (obs[i] > 9824 - 4200) && (obs[i] < 9824 + 4200), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
